ai_qram_arbiter: RTL and testbench

Round-robin arbiter that shares the single QRAM streaming read port among the four AI comparer cores. Each core issues 16-bit word-address read requests and receives a 32-bit result. The arbiter serialises these requests onto the 32-bit address stream and returns the selected half of the 64-bit data stream to the winning core. It sits between the four `AI_core` instances and the comparer's QRAM master/slave stream ports, and includes a per-transaction timeout so a stalled QRAM cannot hang a core.

---
 rtl/ai_qram_arbiter.sv | 132 +++++++++++++
 tb/tb_ai_qram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_qram_arbiter.sv
// Round-robin arbiter sharing one QRAM streaming read port among four AI comparer cores.
// One transaction in flight; a per-transaction watchdog completes a stalled read with zero data.
module ai_qram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic        init,
  input  logic [3:0]  req_read,
  input  logic [63:0] req_addr,
  output logic [3:0]  req_rdy,
  output logic [31:0] req_data,
  output logic [31:0] avm_m2_dout,
  output logic        avm_m2_valid,
  input  logic        avm_m2_ready,
  input  logic [63:0] avm_s2_dout,
  input  logic        avm_s2_valid,
  output logic        avm_s2_ready,
  output logic        tmo_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);

  state_t      r_state;
  logic [1:0]  r_id;
  logic [1:0]  r_lastGrant;
  logic        r_addrLsb;
  logic [9:0]  r_cnt;

  logic        w_grantValid;
  logic [1:0]  w_grantId;
  logic [15:0] w_grantAddr;
  logic        w_abort;

  // Search upward from the core after the last winner; k = 4 wraps back to the last winner itself.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantId    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_grantValid && req_read[r_lastGrant + 2'(k)]) begin
        w_grantValid = 1'b1;
        w_grantId    = r_lastGrant + 2'(k);
      end
    end
  end

  assign w_grantAddr = req_addr[{w_grantId, 4'b0000} +: 16];

  // Data arriving on the limit cycle still counts as a normal completion.
  assign w_abort = (r_state != ST_IDLE) && (r_cnt == TMO_LIMIT) &&
                   !((r_state == ST_DATA) && avm_s2_valid);

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_state      <= ST_IDLE;
      r_id         <= 2'd0;
      r_lastGrant  <= 2'd3;
      r_addrLsb    <= 1'b0;
      r_cnt        <= 10'd0;
      req_rdy      <= 4'd0;
      req_data     <= 32'd0;
      avm_m2_dout  <= 32'd0;
      avm_m2_valid <= 1'b0;
      avm_s2_ready <= 1'b0;
      tmo_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_rdy <= 4'd0;
      tmo_err <= 1'b0;
      if (init) begin
        r_state      <= ST_IDLE;
        r_lastGrant  <= 2'd3;
        r_cnt        <= 10'd0;
        avm_m2_valid <= 1'b0;
        avm_s2_ready <= 1'b0;
        busy         <= 1'b0;
      end else if (w_abort) begin
        r_state      <= ST_IDLE;
        r_lastGrant  <= r_id;
        req_rdy      <= 4'b0001 << r_id;
        req_data     <= 32'd0;
        tmo_err      <= 1'b1;
        avm_m2_valid <= 1'b0;
        avm_s2_ready <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_grantValid) begin
              r_id         <= w_grantId;
              r_addrLsb    <= w_grantAddr[0];
              r_cnt        <= 10'd0;
              avm_m2_dout  <= {BASE_ADDR[31:18], w_grantId, w_grantAddr[15:1], 1'b0};
              avm_m2_valid <= 1'b1;
              busy         <= 1'b1;
              r_state      <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            r_cnt <= r_cnt + 10'd1;
            if (avm_m2_ready) begin
              avm_m2_valid <= 1'b0;
              avm_s2_ready <= 1'b1;
              r_state      <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_cnt <= r_cnt + 10'd1;
            if (avm_s2_valid) begin
              req_data     <= r_addrLsb ? avm_s2_dout[63:32] : avm_s2_dout[31:0];
              req_rdy      <= 4'b0001 << r_id;
              r_lastGrant  <= r_id;
              avm_s2_ready <= 1'b0;
              busy         <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ai_qram_arbiter.sv
// Scoreboard bench for ai_qram_arbiter: a QRAM slave model with programmable stalls,
// a round-robin reference model that queues expected completions, and a negedge monitor.
module tb_ai_qram_arbiter;

  localparam logic [31:0] BASE = 32'h0004_0000;
  localparam int          TMO  = 8;

  logic        csi_clk      = 1'b0;
  logic        rsi_reset_n  = 1'b0;
  logic        init         = 1'b0;
  logic [3:0]  req_read     = 4'd0;
  logic [63:0] req_addr     = 64'd0;
  logic        avm_m2_ready = 1'b0;
  logic [63:0] avm_s2_dout  = 64'd0;
  logic        avm_s2_valid = 1'b0;
  logic [3:0]  req_rdy;
  logic [31:0] req_data;
  logic [31:0] avm_m2_dout;
  logic        avm_m2_valid;
  logic        avm_s2_ready;
  logic        tmo_err;
  logic        busy;

  ai_qram_arbiter #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n), .init(init),
    .req_read(req_read), .req_addr(req_addr), .req_rdy(req_rdy), .req_data(req_data),
    .avm_m2_dout(avm_m2_dout), .avm_m2_valid(avm_m2_valid), .avm_m2_ready(avm_m2_ready),
    .avm_s2_dout(avm_s2_dout), .avm_s2_valid(avm_s2_valid), .avm_s2_ready(avm_s2_ready),
    .tmo_err(tmo_err), .busy(busy)
  );

  initial forever #5 csi_clk = ~csi_clk;

  typedef struct {
    int          core;
    logic [31:0] addr;
    logic [31:0] data;
    logic        tmo;
    int          cyc;
  } exp_t;

  exp_t        expQ[$];
  int          nChecks     = 0;
  int          nFails      = 0;
  int          cycle       = 0;
  int          lastGrant   = 3;
  bit          holdReq     = 1'b0;
  int          slvAddrWait = 0;
  int          slvDataWait = 0;
  bit          slvUseFixed = 1'b0;
  logic [63:0] slvFixed    = 64'd0;
  logic [31:0] slvCaptured = 32'd0;

  initial forever begin
    @(posedge csi_clk);
    cycle++;
  end

  // QRAM contents are a fixed scramble of the word address.
  function automatic logic [63:0] qramWord(input logic [31:0] a);
    return {a * 32'h9E37_79B1, a ^ 32'hA5A5_5A5A};
  endfunction

  // Every ADDR/DATA cycle consumes one count; data on the final count still wins.
  function automatic bit predTimeout(input int a, input int d);
    return (a >= TMO) || (a + 1 + d > TMO);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic tick();
    @(posedge csi_clk);
    #1;
    if (!holdReq) req_read = req_read & ~req_rdy;
  endtask

  task automatic pushExpected(input int g, input logic [63:0] addrs, input int a, input int d, inout int c);
    exp_t        e;
    logic [15:0] ca;
    logic [63:0] w;
    ca     = addrs[16*g +: 16];
    e.core = g;
    e.tmo  = predTimeout(a, d);
    e.addr = (BASE & 32'hFFFC_0000) | (32'(g) << 16) | {16'h0000, ca & 16'hFFFE};
    w      = slvUseFixed ? slvFixed : qramWord(e.addr);
    e.data = e.tmo ? 32'd0 : (ca[0] ? w[63:32] : w[31:0]);
    c      = c + (e.tmo ? TMO + 2 : a + d + 3);
    e.cyc  = c;
    lastGrant = g;
    expQ.push_back(e);
  endtask

  task automatic drainQueue(input string name);
    for (int i = 0; i < 400 && expQ.size() != 0; i++) tick();
    if (expQ.size() != 0) begin
      checkOutput(name, 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  // Raise a set of requests together; the model predicts round-robin completion order and timing.
  task automatic applyStimulus(input logic [3:0] mask, input logic [63:0] addrs, input int a, input int d);
    logic [3:0] pend;
    int         c;
    int         g;
    tick();
    c           = cycle;
    slvAddrWait = a;
    slvDataWait = d;
    pend        = mask;
    while (pend != 4'd0) begin
      g = 0;
      for (int k = 1; k <= 4; k++) begin
        if (pend[(lastGrant + k) % 4]) begin
          g = (lastGrant + k) % 4;
          break;
        end
      end
      pend[g] = 1'b0;
      pushExpected(g, addrs, a, d, c);
    end
    req_addr = addrs;
    req_read = mask;
    drainQueue("drain_timeout");
    req_read = 4'd0;
  endtask

  task automatic runFairness(input logic [63:0] addrs);
    int c;
    int n;
    tick();
    c           = cycle;
    n           = 0;
    slvAddrWait = 0;
    slvDataWait = 0;
    for (int k = 0; k < 8; k++) pushExpected((lastGrant + 1) % 4, addrs, 0, 0, c);
    holdReq  = 1'b1;
    req_addr = addrs;
    req_read = 4'hF;
    for (int i = 0; i < 200 && n < 8; i++) begin
      tick();
      if (req_rdy != 4'd0) n++;
    end
    req_read = 4'd0;
    holdReq  = 1'b0;
    drainQueue("fairness_drain");
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_req_rdy"},  req_rdy,      0);
    checkOutput({name, "_req_data"}, req_data,     0);
    checkOutput({name, "_m2_dout"},  avm_m2_dout,  0);
    checkOutput({name, "_m2_valid"}, avm_m2_valid, 0);
    checkOutput({name, "_s2_ready"}, avm_s2_ready, 0);
    checkOutput({name, "_tmo_err"},  tmo_err,      0);
    checkOutput({name, "_busy"},     busy,         0);
  endtask

  // init lands in the very cycle the slave presents data, so the completion must be swallowed.
  task automatic runInitAbort(input logic [63:0] addrs);
    int c;
    tick();
    c           = cycle;
    slvAddrWait = 0;
    slvDataWait = 0;
    req_addr    = addrs;
    pushExpected(1, addrs, 0, 0, c);
    req_read = 4'b0010;
    for (int i = 0; i < 20 && !avm_s2_ready; i++) tick();
    checkOutput("init_reached_data", avm_s2_ready, 1);
    init = 1'b1;
    expQ.delete();
    lastGrant = 3;
    tick();
    init     = 1'b0;
    req_read = 4'd0;
    checkOutput("init_busy",     busy,         0);
    checkOutput("init_s2_ready", avm_s2_ready, 0);
    checkOutput("init_m2_valid", avm_m2_valid, 0);
    checkOutput("init_req_rdy",  req_rdy,      0);
    checkOutput("init_tmo_err",  tmo_err,      0);
    applyStimulus(4'b0101, {$urandom, $urandom}, 0, 0);
  endtask

  task automatic runResetAbort(input logic [63:0] addrs);
    int c;
    tick();
    c           = cycle;
    slvAddrWait = 50;
    slvDataWait = 0;
    req_addr    = addrs;
    pushExpected(2, addrs, 50, 0, c);
    req_read = 4'b0100;
    for (int i = 0; i < 20 && !avm_m2_valid; i++) tick();
    tick();
    checkOutput("reset_pre_m2_valid", avm_m2_valid, 1);
    #3;
    rsi_reset_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    expQ.delete();
    req_read    = 4'd0;
    lastGrant   = 3;
    slvAddrWait = 0;
    tick();
    tick();
    rsi_reset_n = 1'b1;
    tick();
  endtask

  // QRAM slave: stalls address/data by programmed counts and throws noise while not being read.
  initial begin : slave
    int aCnt;
    int dCnt;
    aCnt = 0;
    dCnt = 0;
    forever begin
      @(posedge csi_clk);
      #1;
      if (avm_m2_valid) begin
        avm_m2_ready = (aCnt >= slvAddrWait);
        if (avm_m2_ready) slvCaptured = avm_m2_dout;
        aCnt++;
      end else begin
        aCnt = 0;
        avm_m2_ready = 1'($urandom_range(0, 1));
      end
      if (avm_s2_ready) begin
        avm_s2_valid = (dCnt >= slvDataWait);
        avm_s2_dout  = avm_s2_valid ? (slvUseFixed ? slvFixed : qramWord(slvCaptured))
                                    : {$urandom, $urandom};
        dCnt++;
      end else begin
        dCnt = 0;
        avm_s2_valid = 1'($urandom_range(0, 1));
        avm_s2_dout  = {$urandom, $urandom};
      end
    end
  end

  // Monitor: every valid address must belong to the oldest outstanding read; every pulse pops one entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge csi_clk);
      if (rsi_reset_n) begin
        if (avm_m2_valid) begin
          if (expQ.size() == 0) checkOutput("m2_valid_unexpected", avm_m2_valid, 0);
          else checkOutput("m2_dout", avm_m2_dout, expQ[0].addr);
        end
        if (req_rdy != 4'd0) begin
          if (expQ.size() == 0) begin
            checkOutput("req_rdy_unexpected", req_rdy, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("req_rdy",    req_rdy,  4'b0001 << e.core);
            checkOutput("req_data",   req_data, e.data);
            checkOutput("tmo_err",    tmo_err,  e.tmo);
            checkOutput("busy_at_rdy", busy,    0);
            checkOutput("rdy_cycle",  64'(cycle), 64'(e.cyc));
          end
        end else if (tmo_err) begin
          checkOutput("tmo_without_rdy", tmo_err, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge csi_clk);
    #1;
    checkAllZero("reset");
    rsi_reset_n = 1'b1;

    $display("[TB] single read, low half");
    slvUseFixed = 1'b1;
    slvFixed    = 64'hAAAA_BBBB_CCCC_DDDD;
    applyStimulus(4'b0010, {16'h1111, 16'h2222, 16'h0010, 16'h3333}, 0, 0);
    $display("[TB] single read, upper half");
    applyStimulus(4'b1000, {16'h0003, 16'h4444, 16'h5555, 16'h6666}, 0, 0);
    slvUseFixed = 1'b0;

    $display("[TB] fairness");
    tick();
    init = 1'b1;
    tick();
    init      = 1'b0;
    lastGrant = 3;
    runFairness({$urandom, $urandom});

    $display("[TB] backpressure");
    applyStimulus(4'b0001, {$urandom, $urandom}, 5, 0);

    $display("[TB] timeout cases");
    applyStimulus(4'b0100, {$urandom, $urandom}, 0, 100);
    applyStimulus(4'b0100, {$urandom, $urandom}, 0, 0);
    applyStimulus(4'b0001, {$urandom, $urandom}, 0, TMO - 1);
    applyStimulus(4'b0001, {$urandom, $urandom}, 0, TMO);
    applyStimulus(4'b0010, {$urandom, $urandom}, TMO, 0);

    $display("[TB] init and reset aborts");
    runInitAbort({$urandom, $urandom});
    runResetAbort({$urandom, $urandom});

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom_range(1, 15)), {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 8)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
